// File: rtl/m_regfile_scoreboard.sv
// Register file with two combinational read ports, one write-back port and a
// per-register busy scoreboard that flags operands still waiting on a producer.
module m_regfile_scoreboard #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter bit          BYPASS     = 1'b1,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                       w_clock,
  input  logic                       w_reset,
  input  logic [ADDR_WIDTH-1:0]      w_bus_rd_addr_a,
  input  logic [ADDR_WIDTH-1:0]      w_bus_rd_addr_b,
  output logic [DATA_WIDTH-1:0]      w_bus_rd_data_a,
  output logic [DATA_WIDTH-1:0]      w_bus_rd_data_b,
  input  logic                       w_write_back,
  input  logic [ADDR_WIDTH-1:0]      w_bus_write_back_reg,
  input  logic [DATA_WIDTH-1:0]      w_bus_write_back_value,
  input  logic                       w_reserve,
  input  logic [ADDR_WIDTH-1:0]      w_bus_reserve_reg,
  output logic                       w_rd_busy_a,
  output logic                       w_rd_busy_b,
  output logic                       w_stall,
  output logic [(1<<ADDR_WIDTH)-1:0] w_bus_busy_map,
  output logic                       w_err_unreserved
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic                  err;

  logic wr_ok;
  logic rsv_ok;
  logic zero_a;
  logic zero_b;
  logic bypass_hit_a;
  logic bypass_hit_b;

  // Register 0 (when hardwired) swallows writes and reservations entirely.
  assign wr_ok  = w_write_back && !(ZERO_REG && (w_bus_write_back_reg == '0));
  assign rsv_ok = w_reserve && !(ZERO_REG && (w_bus_reserve_reg == '0));

  assign zero_a       = ZERO_REG && (w_bus_rd_addr_a == '0);
  assign zero_b       = ZERO_REG && (w_bus_rd_addr_b == '0);
  assign bypass_hit_a = BYPASS && w_write_back && (w_bus_write_back_reg == w_bus_rd_addr_a);
  assign bypass_hit_b = BYPASS && w_write_back && (w_bus_write_back_reg == w_bus_rd_addr_b);

  always_comb begin
    w_bus_rd_data_a = regs[w_bus_rd_addr_a];
    w_bus_rd_data_b = regs[w_bus_rd_addr_b];
    w_rd_busy_a     = busy[w_bus_rd_addr_a] & ~bypass_hit_a;
    w_rd_busy_b     = busy[w_bus_rd_addr_b] & ~bypass_hit_b;
    if (bypass_hit_a) w_bus_rd_data_a = w_bus_write_back_value;
    if (bypass_hit_b) w_bus_rd_data_b = w_bus_write_back_value;
    if (zero_a) begin
      w_bus_rd_data_a = '0;
      w_rd_busy_a     = 1'b0;
    end
    if (zero_b) begin
      w_bus_rd_data_b = '0;
      w_rd_busy_b     = 1'b0;
    end
  end

  assign w_stall          = w_rd_busy_a | w_rd_busy_b;
  assign w_bus_busy_map   = busy;
  assign w_err_unreserved = err;

  // A reserve applied after the release lets a new producer win a same-edge collision.
  always_comb begin
    busy_next = busy;
    if (wr_ok)  busy_next[w_bus_write_back_reg] = 1'b0;
    if (rsv_ok) busy_next[w_bus_reserve_reg]    = 1'b1;
  end

  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
      err  <= 1'b0;
    end else begin
      if (wr_ok) regs[w_bus_write_back_reg] <= w_bus_write_back_value;
      if (wr_ok && !busy[w_bus_write_back_reg]) err <= 1'b1;
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_m_regfile_scoreboard.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a monitor on the
// falling edge pops and compares them against a BYPASS=1 and a BYPASS=0 instance.
module tb_m_regfile_scoreboard;

   localparam int DW = 8;
   localparam int AW = 4;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } check_t;

   localparam int S_DATA_A = 0, S_DATA_B = 1, S_BUSY_A = 2, S_BUSY_B = 3, S_STALL = 4,
                  S_MAP = 5, S_ERR = 6, S_NB_DATA_A = 7, S_NB_DATA_B = 8, S_NB_STALL = 9;

   logic            w_clock = 1'b0;
   logic            w_reset = 1'b1;
   logic [AW-1:0]   rd_addr_a = '0;
   logic [AW-1:0]   rd_addr_b = '0;
   logic            write_back = 1'b0;
   logic [AW-1:0]   write_back_reg = '0;
   logic [DW-1:0]   write_back_value = '0;
   logic            reserve = 1'b0;
   logic [AW-1:0]   reserve_reg = '0;

   logic [DW-1:0]   rd_data_a, rd_data_b;
   logic            rd_busy_a, rd_busy_b, stall, err_unreserved;
   logic [(1<<AW)-1:0] busy_map;

   logic [DW-1:0]   nb_rd_data_a, nb_rd_data_b;
   logic            nb_rd_busy_a, nb_rd_busy_b, nb_stall, nb_err_unreserved;
   logic [(1<<AW)-1:0] nb_busy_map;

   check_t exp_q[$];
   int     total = 0;
   int     bad = 0;
   bit     stim_done = 1'b0;

   // Free-running clock with a 10-unit period.
   always #5 w_clock = ~w_clock;

   m_regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut (
      .w_clock(w_clock), .w_reset(w_reset),
      .w_bus_rd_addr_a(rd_addr_a), .w_bus_rd_addr_b(rd_addr_b),
      .w_bus_rd_data_a(rd_data_a), .w_bus_rd_data_b(rd_data_b),
      .w_write_back(write_back), .w_bus_write_back_reg(write_back_reg),
      .w_bus_write_back_value(write_back_value),
      .w_reserve(reserve), .w_bus_reserve_reg(reserve_reg),
      .w_rd_busy_a(rd_busy_a), .w_rd_busy_b(rd_busy_b), .w_stall(stall),
      .w_bus_busy_map(busy_map), .w_err_unreserved(err_unreserved)
   );

   m_regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_nb (
      .w_clock(w_clock), .w_reset(w_reset),
      .w_bus_rd_addr_a(rd_addr_a), .w_bus_rd_addr_b(rd_addr_b),
      .w_bus_rd_data_a(nb_rd_data_a), .w_bus_rd_data_b(nb_rd_data_b),
      .w_write_back(write_back), .w_bus_write_back_reg(write_back_reg),
      .w_bus_write_back_value(write_back_value),
      .w_reserve(reserve), .w_bus_reserve_reg(reserve_reg),
      .w_rd_busy_a(nb_rd_busy_a), .w_rd_busy_b(nb_rd_busy_b), .w_stall(nb_stall),
      .w_bus_busy_map(nb_busy_map), .w_err_unreserved(nb_err_unreserved)
   );

   function automatic logic [31:0] observe(int sel);
      case (sel)
         S_DATA_A:    observe = 32'(rd_data_a);
         S_DATA_B:    observe = 32'(rd_data_b);
         S_BUSY_A:    observe = 32'(rd_busy_a);
         S_BUSY_B:    observe = 32'(rd_busy_b);
         S_STALL:     observe = 32'(stall);
         S_MAP:       observe = 32'(busy_map);
         S_ERR:       observe = 32'(err_unreserved);
         S_NB_DATA_A: observe = 32'(nb_rd_data_a);
         S_NB_DATA_B: observe = 32'(nb_rd_data_b);
         S_NB_STALL:  observe = 32'(nb_stall);
         default:     observe = 32'hDEAD_BEEF;
      endcase
   endfunction

   // Drive one cycle's inputs just after the rising edge; they take effect on the next edge.
   task automatic applyStimulus(input logic rst, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                                input logic we, input logic [AW-1:0] wreg, input logic [DW-1:0] wval,
                                input logic rsv, input logic [AW-1:0] rreg);
      @(posedge w_clock);
      #1;
      w_reset          = rst;
      rd_addr_a        = ra;
      rd_addr_b        = rb;
      write_back       = we;
      write_back_reg   = wreg;
      write_back_value = wval;
      reserve          = rsv;
      reserve_reg      = rreg;
   endtask

   task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
      check_t c;
      c.name = name;
      c.sel  = sel;
      c.exp  = exp;
      exp_q.push_back(c);
   endtask

   // Monitor: on each falling edge compare every queued expectation against the DUT outputs.
   initial begin : monitor
      check_t c;
      logic [31:0] act;
      forever begin
         @(negedge w_clock);
         while (exp_q.size() > 0) begin
            c   = exp_q.pop_front();
            act = observe(c.sel);
            total++;
            if (act !== c.exp) begin
               bad++;
               $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
            end
         end
         if (stim_done) begin
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
      end
   end

   // Watchdog: abort if the bench never reaches its end.
   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] bench timed out");
   end

   // Stimulus: walk through every scenario of the test plan.
   initial begin : stimulus
      applyStimulus(1, 0, 0, 0, 0, 8'h00, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 8'h00, 0, 0);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, AW'(i), AW'(15 - i), 0, 0, 8'h00, 0, 0);
         checkOutput($sformatf("reset_rd_a_r%0d", i), S_DATA_A, 32'h0);
         checkOutput($sformatf("reset_rd_b_r%0d", 15 - i), S_DATA_B, 32'h0);
         if (i == 0) begin
            checkOutput("reset_busy_map", S_MAP, 32'h0);
            checkOutput("reset_err", S_ERR, 32'h0);
            checkOutput("reset_stall", S_STALL, 32'h0);
         end
      end

      applyStimulus(0, 5, 0, 0, 0, 8'h00, 1, 5);
      checkOutput("pre_reserve_busy_a", S_BUSY_A, 32'h0);
      applyStimulus(0, 5, 0, 0, 0, 8'h00, 0, 0);
      checkOutput("r5_busy_map", S_MAP, 32'h0020);
      checkOutput("r5_busy_a", S_BUSY_A, 32'h1);
      checkOutput("r5_stall", S_STALL, 32'h1);
      applyStimulus(0, 5, 0, 1, 5, 8'hA7, 0, 0);
      checkOutput("r5_bypass_data_a", S_DATA_A, 32'hA7);
      checkOutput("r5_bypass_busy_a", S_BUSY_A, 32'h0);
      applyStimulus(0, 5, 0, 0, 0, 8'h00, 0, 0);
      checkOutput("r5_stored_data_a", S_DATA_A, 32'hA7);
      checkOutput("r5_released_map", S_MAP, 32'h0);
      checkOutput("r5_released_busy_a", S_BUSY_A, 32'h0);
      checkOutput("r5_no_err", S_ERR, 32'h0);
      checkOutput("nb_r5_stored_data_a", S_NB_DATA_A, 32'hA7);

      applyStimulus(0, 0, 0, 0, 0, 8'h00, 1, 3);
      applyStimulus(0, 0, 3, 1, 3, 8'h5C, 0, 0);
      checkOutput("r3_busy_map", S_MAP, 32'h0008);
      checkOutput("r3_bypass_data_b", S_DATA_B, 32'h5C);
      checkOutput("r3_bypass_busy_b", S_BUSY_B, 32'h0);
      checkOutput("r3_bypass_stall", S_STALL, 32'h0);
      checkOutput("nb_r3_old_data_b", S_NB_DATA_B, 32'h0);
      checkOutput("nb_r3_stall", S_NB_STALL, 32'h1);

      applyStimulus(0, 0, 3, 0, 0, 8'h00, 1, 9);
      checkOutput("r3_released_map", S_MAP, 32'h0);
      checkOutput("nb_r3_stored_data_b", S_NB_DATA_B, 32'h5C);
      applyStimulus(0, 9, 0, 1, 9, 8'h11, 1, 9);
      checkOutput("r9_busy_map", S_MAP, 32'h0200);
      checkOutput("r9_bypass_data_a", S_DATA_A, 32'h11);
      checkOutput("r9_bypass_busy_a", S_BUSY_A, 32'h0);
      applyStimulus(0, 9, 0, 0, 0, 8'h00, 0, 0);
      checkOutput("r9_collide_data_a", S_DATA_A, 32'h11);
      checkOutput("r9_collide_map", S_MAP, 32'h0200);
      checkOutput("r9_collide_busy_a", S_BUSY_A, 32'h1);
      checkOutput("r9_collide_err", S_ERR, 32'h0);
      applyStimulus(0, 0, 0, 1, 9, 8'h12, 0, 0);

      applyStimulus(0, 0, 0, 1, 0, 8'hFF, 1, 0);
      checkOutput("r0_bypass_data_a", S_DATA_A, 32'h0);
      checkOutput("r0_bypass_busy_a", S_BUSY_A, 32'h0);
      applyStimulus(0, 0, 9, 0, 0, 8'h00, 0, 0);
      checkOutput("r0_data_a", S_DATA_A, 32'h0);
      checkOutput("r0_busy_map", S_MAP, 32'h0);
      checkOutput("r0_no_err", S_ERR, 32'h0);
      checkOutput("r9_final_data_b", S_DATA_B, 32'h12);

      applyStimulus(0, 0, 2, 1, 2, 8'h33, 0, 0);
      checkOutput("r2_bypass_data_b", S_DATA_B, 32'h33);
      checkOutput("r2_err_before_edge", S_ERR, 32'h0);
      applyStimulus(0, 0, 2, 0, 0, 8'h00, 0, 0);
      checkOutput("r2_data_b", S_DATA_B, 32'h33);
      checkOutput("r2_err_set", S_ERR, 32'h1);
      applyStimulus(0, 7, 2, 0, 0, 8'h00, 0, 0);
      checkOutput("err_sticky", S_ERR, 32'h1);

      applyStimulus(1, 7, 2, 1, 7, 8'h42, 1, 7);
      checkOutput("err_before_reset_edge", S_ERR, 32'h1);
      applyStimulus(0, 7, 2, 0, 0, 8'h00, 0, 0);
      checkOutput("r7_after_reset", S_DATA_A, 32'h0);
      checkOutput("r2_after_reset", S_DATA_B, 32'h0);
      checkOutput("map_after_reset", S_MAP, 32'h0);
      checkOutput("err_after_reset", S_ERR, 32'h0);
      checkOutput("stall_after_reset", S_STALL, 32'h0);

      #2;
      total++;
      if (rd_data_a !== 8'h00) begin
         bad++;
         $display("[TB] FAIL direct_r7_after_reset: got 0x%0h expected 0x0", rd_data_a);
      end
      total++;
      if (rd_data_b !== 8'h00) begin
         bad++;
         $display("[TB] FAIL direct_r2_after_reset: got 0x%0h expected 0x0", rd_data_b);
      end
      total++;
      if (busy_map !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL direct_map_after_reset: got 0x%0h expected 0x0", busy_map);
      end
      total++;
      if (err_unreserved !== 1'b0) begin
         bad++;
         $display("[TB] FAIL direct_err_after_reset: got 0x%0h expected 0x0", err_unreserved);
      end
      total++;
      if (stall !== 1'b0) begin
         bad++;
         $display("[TB] FAIL direct_stall_after_reset: got 0x%0h expected 0x0", stall);
      end

      stim_done = 1'b1;
   end

endmodule
